// File: rtl/clock_display_if.sv
// clock_display_if: time input strobe and multiplexed 7-segment outputs of clock_display.
//   hours/minutes/seconds/time_valid : binary time and one-cycle valid strobe (master -> slave)
//   an/seg/dp/err                    : active-low digit enables, segments {g..a}, colon, sticky error (slave -> master)
interface clock_display_if;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       time_valid;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       err;
  modport master (output hours, minutes, seconds, time_valid, input an, seg, dp, err);
  modport slave  (input hours, minutes, seconds, time_valid, output an, seg, dp, err);
endinterface

// File: rtl/clock_display.sv
// clock_display: captures HH:MM:SS, converts to BCD and scans six common-anode 7-segment digits with a blinking colon.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : clock_display_if.slave (time strobe in, an/seg/dp/err out)
//   DIGIT_CYCLES : clk cycles per digit slot (>= 2), first cycle of each slot is blanked
//   Define CLOCK_DISP_LZB_EN to blank the hours-tens digit when it is zero.
module clock_display #(
  parameter int DIGIT_CYCLES = 5
) (
  input logic            clk,
  input logic            rst,
  clock_display_if.slave bus
);
  localparam int DW = $clog2(DIGIT_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DIGIT_CYCLES - 1);
  logic [4:0] hrs_q, hrs_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic colon_q, colon_d, err_q, err_d, conv_q, conv_d;
  logic [0:5][3:0] bcd_q, bcd_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0] idx_q, idx_d;
  logic [5:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d, ok, blank;
  // Compare chain for tens; ones uses mod-16 arithmetic since v - 10*tens is always 0..9.
  function automatic logic [7:0] split(input logic [5:0] v);
    logic [3:0] t;
    t = v >= 6'd50 ? 4'd5 : v >= 6'd40 ? 4'd4 : v >= 6'd30 ? 4'd3 :
        v >= 6'd20 ? 4'd2 : v >= 6'd10 ? 4'd1 : 4'd0;
    return {t, v[3:0] - t * 4'd10};
  endfunction
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  always_comb begin
    ok = bus.time_valid && bus.hours <= 5'd23 && bus.minutes <= 6'd59 && bus.seconds <= 6'd59;
    hrs_d = ok ? bus.hours : hrs_q;
    min_d = ok ? bus.minutes : min_q;
    sec_d = ok ? bus.seconds : sec_q;
    colon_d = colon_q ^ ok;
    err_d = err_q | (bus.time_valid & ~ok);
    conv_d = ok;
    bcd_d = conv_q ? {split({1'b0, hrs_q}), split(min_q), split(sec_q)} : bcd_q;
    dwell_d = dwell_q == LAST ? '0 : dwell_q + DW'(1);
    idx_d = dwell_q != LAST ? idx_q : idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
`ifdef CLOCK_DISP_LZB_EN
    blank = dwell_d == '0 || (idx_d == 3'd0 && bcd_q[0] == 4'd0);
`else
    blank = dwell_d == '0;
`endif
    // Outputs follow the next-state scan position so they line up with idx/dwell.
    an_d = blank ? 6'b111111 : ~(6'b100000 >> idx_d);
    seg_d = seg7(bcd_q[idx_d]);
    dp_d = !(dwell_d != '0 && colon_q && (idx_d == 3'd1 || idx_d == 3'd3));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hrs_q <= '0;
      min_q <= '0;
      sec_q <= '0;
      colon_q <= 1'b0;
      err_q <= 1'b0;
      conv_q <= 1'b0;
      bcd_q <= '0;
      dwell_q <= '0;
      idx_q <= '0;
      an_q <= 6'b111111;
      seg_q <= 7'b1111111;
      dp_q <= 1'b1;
    end else begin
      hrs_q <= hrs_d;
      min_q <= min_d;
      sec_q <= sec_d;
      colon_q <= colon_d;
      err_q <= err_d;
      conv_q <= conv_d;
      bcd_q <= bcd_d;
      dwell_q <= dwell_d;
      idx_q <= idx_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign bus.an = an_q;
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_clock_display.sv
// tb_clock_display: directed checks of capture, reject, BCD scan, colon and async reset of clock_display.
module tb_clock_display;
  localparam int DC = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int md = 0;
  int mi = 0;
  logic [3:0] exp_d [6];
  bit exp_c = 1'b0;
  clock_display_if bus ();
  clock_display #(.DIGIT_CYCLES(DC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] segtab(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  task automatic set_digits(input int a, b, c, d, e, f);
    exp_d[0] = 4'(a); exp_d[1] = 4'(b); exp_d[2] = 4'(c);
    exp_d[3] = 4'(d); exp_d[4] = 4'(e); exp_d[5] = 4'(f);
  endtask
  task automatic run(input int n, input bit en);
    logic [5:0] ea;
    logic ed;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (md == DC - 1) begin
        md = 0;
        mi = mi == 5 ? 0 : mi + 1;
      end else md++;
      @(negedge clk);
      if (en) begin
        ea = md == 0 ? 6'b111111 : ~(6'b100000 >> mi);
`ifdef CLOCK_DISP_LZB_EN
        if (mi == 0 && exp_d[0] == 4'd0) ea = 6'b111111;
`endif
        ed = ((mi == 1 || mi == 3) && exp_c && md != 0) ? 1'b0 : 1'b1;
        check("an", 32'(bus.an), 32'(ea));
        if (md != 0) check("seg", 32'(bus.seg), 32'(segtab(exp_d[mi])));
        check("dp", 32'(bus.dp), 32'(ed));
      end
    end
  endtask
  task automatic strobe(input int h, m, s);
    bus.hours = 5'(h);
    bus.minutes = 6'(m);
    bus.seconds = 6'(s);
    bus.time_valid = 1'b1;
    run(1, 0);
    bus.time_valid = 1'b0;
  endtask
  initial begin
    bus.hours = '0;
    bus.minutes = '0;
    bus.seconds = '0;
    bus.time_valid = 1'b0;
    set_digits(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_an", 32'(bus.an), 32'h3f);
    check("rst_seg", 32'(bus.seg), 32'h7f);
    check("rst_dp", 32'(bus.dp), 32'h1);
    check("rst_err", 32'(bus.err), 32'h0);
    rst = 1'b0;
    run(30, 1);
    strobe(23, 59, 58);
    check("err_legal", 32'(bus.err), 32'h0);
    set_digits(2, 3, 5, 9, 5, 8);
    exp_c = 1'b1;
    run(1, 0);
    run(30, 1);
    strobe(0, 0, 0);
    set_digits(0, 0, 0, 0, 0, 0);
    exp_c = 1'b0;
    run(1, 0);
    run(30, 1);
    check("err_zero", 32'(bus.err), 32'h0);
    strobe(24, 0, 0);
    check("err_bad_hours", 32'(bus.err), 32'h1);
    run(30, 1);
    strobe(12, 34, 56);
    check("err_sticky", 32'(bus.err), 32'h1);
    set_digits(1, 2, 3, 4, 5, 6);
    exp_c = 1'b1;
    run(1, 0);
    run(30, 1);
    strobe(5, 60, 0);
    check("err_bad_min", 32'(bus.err), 32'h1);
    run(12, 1);
    bus.hours = 5'd10; bus.minutes = 6'd20; bus.seconds = 6'd30;
    bus.time_valid = 1'b1;
    run(1, 0);
    bus.hours = 5'd11; bus.minutes = 6'd21; bus.seconds = 6'd31;
    run(1, 0);
    bus.time_valid = 1'b0;
    set_digits(1, 1, 2, 1, 3, 1);
    run(1, 0);
    run(30, 1);
    for (int i = 0; i < 40 && !(mi == 3 && md == 2); i++) run(1, 1);
    check("reached_idx3", 32'(mi), 32'd3);
    #3 rst = 1'b1;
    #1;
    check("async_an", 32'(bus.an), 32'h3f);
    check("async_seg", 32'(bus.seg), 32'h7f);
    check("async_dp", 32'(bus.dp), 32'h1);
    check("async_err", 32'(bus.err), 32'h0);
    @(negedge clk);
    md = 0;
    mi = 0;
    rst = 1'b0;
    set_digits(0, 0, 0, 0, 0, 0);
    exp_c = 1'b0;
    run(30, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
